mmu_request_arbiter: RTL and testbench
======================================

// Module: mmu_request_arbiter
// PURPOSE
//   Shares the single core->MMU request port among N_REQ requesters (load/store units, I/O issue).
//   Picks one requester round-robin, holds the grant until the MMU accepts, and forwards its fields.
//   Tags each accepted read (I_LOAD/LOADB/LOADR/LOADT/LOADTB/I_INPUT) with its source index in a FIFO.
//   On each CDB handshake it pops a tag and reports which requester the result belongs to.
// PARAMETERS
//   N_REQ      4  number of requesters, >=2
//   TAG_DEPTH  2  read-tag FIFO entries, power of 2
//   (RSV_ID_W, INSTR_W, DATA_W, CDB_W come from fcpu_pkg; SRC_W = $clog2(N_REQ))
// PORTS
//   clk          in   1                clock
//   nrst         in   1                reset, synchronous, active-high
//   req_valid    in   N_REQ            per-requester request valid
//   req_rsv_id   in   N_REQ*RSV_ID_W   per-requester reservation id
//   req_opcode   in   N_REQ*INSTR_W    per-requester opcode
//   req_address  in   N_REQ*DATA_W     per-requester address
//   req_data     in   N_REQ*DATA_W     per-requester store data
//   req_ready    out  N_REQ            accept strobe, one-hot or zero
//   m_valid      out  1                to MMU valid
//   m_rsv_id     out  RSV_ID_W         to MMU rsv_id
//   m_opcode     out  INSTR_W          to MMU opcode
//   m_address    out  DATA_W           to MMU address
//   m_data       out  DATA_W           to MMU data
//   m_ready      in   1                from MMU ready
//   cdb_valid    in   1                MMU o_cdb_valid (observed only)
//   cdb_ready    in   1                CDB consumer ready (observed only)
//   rsp_done     out  N_REQ            1-cycle pulse to the owner of the completed read
//   tag_full     out  1                read-tag FIFO full
//   err_orphan   out  1                sticky: CDB handshake with no tag outstanding
// BEHAVIOUR
//   Reset (nrst=1 at posedge):
//     - state=ARB_IDLE, rr_ptr=0, grant=0, FIFO emptied
//     - err_orphan=0
//     - m_valid, req_ready, rsp_done and tag_full read 0 in the following cycle
//     - Reset mid-operation abandons the held grant; the MMU was not handshaken, so nothing is lost.
//   Requester rule: once req_valid[i]=1, it and i's fields are held stable until req_ready[i].
//   Eligible[i] = req_valid[i] && !(is_read(req_opcode[i]) && tag_full).
//   FSM:
//     ARB_IDLE: m_valid=0, req_ready=0.
//       - If any requester is eligible: grant <= first eligible index scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//       - Then -> ARB_BUSY.
//     ARB_BUSY: m_valid=1, m_* driven combinationally from req_*[grant], req_ready[grant]=m_ready.
//       - On m_valid&&m_ready: rr_ptr <= (grant+1) mod N_REQ; push grant if is_read; -> ARB_IDLE.
//       - Otherwise stay, grant held regardless of other requesters.
//   Latency: request accepted no earlier than the 2nd cycle after req_valid rises.
//     Back-to-back grants therefore come at most every 2 cycles.
//   Tag FIFO and CDB:
//     - pop = cdb_valid && cdb_ready; rsp_done[head] pulses in the same cycle as the pop (combinational).
//     - Push and pop in the same cycle with the FIFO non-empty: both take effect, count unchanged.
//     - Push and pop in the same cycle with the FIFO empty (I_INPUT returns instantly): bypass.
//       rsp_done[grant] pulses and the count stays 0.
//     - Pop with empty FIFO and no push: no rsp_done, err_orphan <= 1 (cleared only by reset).
//     - tag_full = (count == TAG_DEPTH). Read pointers wrap mod TAG_DEPTH.
//     - Stores and I_OUTPUT are never tagged.
// TESTING
//   1. Single request: req_valid[2]=1 with I_STORE, m_ready=1 -> m_valid in cycle 1.
//      req_ready=4'b0100 in that cycle, rr_ptr becomes 3, no rsp_done.
//   2. Fairness: all 4 requesters hold valid, m_ready=1 -> grant order 0,1,2,3,0, one per 2 cycles.
//   3. Backpressure: req0 granted with m_ready=0 for 5 cycles while req1 is valid.
//      -> m_* stay equal to req0 fields and req_ready stays 0 the whole time.
//      Raising m_ready accepts req0, then req1 is granted next.
//   4. Tag flow: loads from req1 then req3 are accepted, then two CDB handshakes.
//      -> rsp_done=4'b0010, then 4'b1000.
//      A third load while tag_full=1 is skipped; a store from another requester is granted instead.
//   5. I_INPUT bypass: empty FIFO, req2 I_INPUT accepted with cdb_valid=cdb_ready=1 in the same cycle.
//      -> rsp_done=4'b0100 that cycle, count stays 0, err_orphan=0.
//   6. Reset/orphan: CDB handshake with empty FIFO -> err_orphan=1.
//      Then nrst=1 in ARB_BUSY -> next cycle m_valid=0, err_orphan=0, FIFO empty, and req0 is granted first.

Source files
------------

// File: rtl/mmu_request_arbiter.sv
// Round-robin arbiter for the shared core->MMU request port. Each accepted read is
// tagged with its source index so that CDB completions can be routed back to their owner.
module mmu_request_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TAG_DEPTH = 2,
    parameter int RSV_ID_W  = 4,
    parameter int INSTR_W   = 8,
    parameter int DATA_W    = 32,
    parameter logic [INSTR_W-1:0] OP_LOAD   = INSTR_W'(1),
    parameter logic [INSTR_W-1:0] OP_LOADB  = INSTR_W'(2),
    parameter logic [INSTR_W-1:0] OP_LOADR  = INSTR_W'(3),
    parameter logic [INSTR_W-1:0] OP_LOADT  = INSTR_W'(4),
    parameter logic [INSTR_W-1:0] OP_LOADTB = INSTR_W'(5),
    parameter logic [INSTR_W-1:0] OP_INPUT  = INSTR_W'(6)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*RSV_ID_W-1:0]    req_rsv_id,
    input  logic [N_REQ*INSTR_W-1:0]     req_opcode,
    input  logic [N_REQ*DATA_W-1:0]      req_address,
    input  logic [N_REQ*DATA_W-1:0]      req_data,
    output logic [N_REQ-1:0]             req_ready,
    output logic                         m_valid,
    output logic [RSV_ID_W-1:0]          m_rsv_id,
    output logic [INSTR_W-1:0]           m_opcode,
    output logic [DATA_W-1:0]            m_address,
    output logic [DATA_W-1:0]            m_data,
    input  logic                         m_ready,
    input  logic                         cdb_valid,
    input  logic                         cdb_ready,
    output logic [N_REQ-1:0]             rsp_done,
    output logic                         tag_full,
    output logic                         err_orphan
);

    localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    arb_state_t         state_r;
    arb_state_t         state_nxt_s;
    logic [SRC_W-1:0]   grant_r;
    logic [SRC_W-1:0]   rr_ptr_r;
    logic [SRC_W-1:0]   pick_s;
    logic               any_elig_s;
    logic [N_REQ-1:0]   elig_s;
    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    logic               wr_en_s;
    logic               rd_en_s;
    logic               orphan_s;
    logic               fifo_empty_s;
    logic               tag_full_s;
    logic [SRC_W-1:0]   tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               err_r;

    function automatic logic is_read(input logic [INSTR_W-1:0] op);
        logic r;
        case (op)
            OP_LOAD, OP_LOADB, OP_LOADR, OP_LOADT, OP_LOADTB, OP_INPUT: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [N_REQ-1:0] src_onehot(input logic [SRC_W-1:0] src);
        logic [N_REQ-1:0] v;
        v = '0;
        v[src] = 1'b1;
        return v;
    endfunction

    // Index k positions after base, wrapping at N_REQ (which need not be a power of two).
    function automatic logic [SRC_W-1:0] rot_idx(input logic [SRC_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        return SRC_W'(s);
    endfunction

    assign fifo_empty_s = (count_r == CNT_W'(0));
    assign tag_full_s   = (count_r == CNT_W'(TAG_DEPTH));
    assign tag_full     = tag_full_s;
    assign err_orphan   = err_r;
    assign hs_s         = m_valid && m_ready;
    assign push_s       = hs_s && is_read(m_opcode);
    assign pop_s        = cdb_valid && cdb_ready;
    // An empty-FIFO push that coincides with a pop is forwarded straight to rsp_done.
    assign wr_en_s      = push_s && !(fifo_empty_s && pop_s);
    assign rd_en_s      = pop_s && !fifo_empty_s;

    // Reads are held back while the tag FIFO has no room for their tag.
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig_s[i] = req_valid[i] && !(is_read(req_opcode[i*INSTR_W +: INSTR_W]) && tag_full_s);
        end
    end

    // First eligible requester at or after rr_ptr; scanned backwards so the nearest wins.
    always_comb begin
        pick_s     = rr_ptr_r;
        any_elig_s = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (elig_s[rot_idx(rr_ptr_r, k)]) begin
                pick_s     = rot_idx(rr_ptr_r, k);
                any_elig_s = 1'b1;
            end else begin
                any_elig_s = any_elig_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (any_elig_s) begin
                    state_nxt_s = ARB_BUSY;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (m_ready) begin
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_BUSY;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // FSM outputs: the granted requester's fields go straight to the MMU port.
    always_comb begin
        m_valid   = 1'b0;
        m_rsv_id  = '0;
        m_opcode  = '0;
        m_address = '0;
        m_data    = '0;
        req_ready = '0;
        if (state_r == ARB_BUSY) begin
            m_valid            = 1'b1;
            m_rsv_id           = req_rsv_id[int'(grant_r)*RSV_ID_W +: RSV_ID_W];
            m_opcode           = req_opcode[int'(grant_r)*INSTR_W +: INSTR_W];
            m_address          = req_address[int'(grant_r)*DATA_W +: DATA_W];
            m_data             = req_data[int'(grant_r)*DATA_W +: DATA_W];
            req_ready[grant_r] = m_ready;
        end else begin
            m_valid = 1'b0;
        end
    end

    // Grant capture and round-robin pointer advance.
    always_ff @(posedge clk) begin
        if (nrst) begin
            grant_r  <= '0;
            rr_ptr_r <= '0;
        end else begin
            if ((state_r == ARB_IDLE) && any_elig_s) begin
                grant_r <= pick_s;
            end else begin
                grant_r <= grant_r;
            end
            if (hs_s) begin
                rr_ptr_r <= (grant_r == SRC_W'(N_REQ - 1)) ? '0 : grant_r + SRC_W'(1);
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Completion routing and orphan detection.
    always_comb begin
        rsp_done = '0;
        orphan_s = 1'b0;
        if (pop_s) begin
            if (!fifo_empty_s) begin
                rsp_done = src_onehot(tag_mem_r[rd_ptr_r]);
            end else if (push_s) begin
                rsp_done = src_onehot(grant_r);
            end else begin
                orphan_s = 1'b1;
            end
        end else begin
            orphan_s = 1'b0;
        end
    end

    // Tag storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            tag_mem_r[wr_ptr_r] <= grant_r;
        end else begin
            tag_mem_r[wr_ptr_r] <= tag_mem_r[wr_ptr_r];
        end
    end

    // Tag FIFO pointers, occupancy and the sticky orphan flag.
    always_ff @(posedge clk) begin
        if (nrst) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (orphan_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// Scoreboard bench for mmu_request_arbiter: a queue/integer reference model predicts
// per-cycle outputs and accepted transactions; a negedge monitor compares them.
module tb_mmu_request_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int RW    = 4;
    localparam int IW    = 8;
    localparam int DW    = 32;
    localparam logic [IW-1:0] OP_LOAD   = 8'h01;
    localparam logic [IW-1:0] OP_LOADB  = 8'h02;
    localparam logic [IW-1:0] OP_LOADR  = 8'h03;
    localparam logic [IW-1:0] OP_LOADT  = 8'h04;
    localparam logic [IW-1:0] OP_LOADTB = 8'h05;
    localparam logic [IW-1:0] OP_INPUT  = 8'h06;
    localparam logic [IW-1:0] OP_STORE  = 8'h07;
    localparam logic [IW-1:0] OP_OUTPUT = 8'h08;

    logic              clk;
    logic              nrst;
    logic [N-1:0]      req_valid;
    logic [N*RW-1:0]   req_rsv_id;
    logic [N*IW-1:0]   req_opcode;
    logic [N*DW-1:0]   req_address;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              m_valid;
    logic [RW-1:0]     m_rsv_id;
    logic [IW-1:0]     m_opcode;
    logic [DW-1:0]     m_address;
    logic [DW-1:0]     m_data;
    logic              m_ready;
    logic              cdb_valid;
    logic              cdb_ready;
    logic [N-1:0]      rsp_done;
    logic              tag_full;
    logic              err_orphan;

    logic              b_valid [N];
    logic [RW-1:0]     b_rsv   [N];
    logic [IW-1:0]     b_op    [N];
    logic [DW-1:0]     b_addr  [N];
    logic [DW-1:0]     b_data  [N];

    typedef struct {
        int           cyc;
        logic         m_valid;
        logic [N-1:0] req_ready;
        logic [N-1:0] rsp_done;
        logic         tag_full;
        logic         err;
    } stat_t;

    typedef struct {
        int            cyc;
        int            src;
        logic [RW-1:0] rsv;
        logic [IW-1:0] op;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    stat_t stat_q[$];
    txn_t  txn_q[$];
    int    acc_log[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc   = 0;
    bit    mon_en = 1'b0;

    // reference model state
    int    mdl_hold = -1;
    int    mdl_rr   = 0;
    int    mdl_tags[$];
    bit    mdl_err  = 1'b0;
    int    acc_idx  = -1;

    mmu_request_arbiter dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_rsv_id(req_rsv_id), .req_opcode(req_opcode),
        .req_address(req_address), .req_data(req_data), .req_ready(req_ready),
        .m_valid(m_valid), .m_rsv_id(m_rsv_id), .m_opcode(m_opcode),
        .m_address(m_address), .m_data(m_data), .m_ready(m_ready),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
        .rsp_done(rsp_done), .tag_full(tag_full), .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_valid   = '0;
        req_rsv_id  = '0;
        req_opcode  = '0;
        req_address = '0;
        req_data    = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i]             = b_valid[i];
            req_rsv_id[i*RW +: RW]   = b_rsv[i];
            req_opcode[i*IW +: IW]   = b_op[i];
            req_address[i*DW +: DW]  = b_addr[i];
            req_data[i*DW +: DW]     = b_data[i];
        end
    end

    function automatic bit ref_is_read(input logic [IW-1:0] op);
        return op inside {OP_LOAD, OP_LOADB, OP_LOADR, OP_LOADT, OP_LOADTB, OP_INPUT};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [IW-1:0] op);
        b_valid[i] = 1'b1;
        b_op[i]    = op;
        b_rsv[i]   = RW'($urandom);
        b_addr[i]  = $urandom;
        b_data[i]  = $urandom;
    endtask

    // Predict this cycle's outputs from the current inputs, then advance the model.
    task automatic eval();
        stat_t s;
        txn_t  t;
        int    push_src;
        bit    pop;
        bit    full;
        bit    was_empty;
        bit    found;
        int    idx;
        full        = (mdl_tags.size() == DEPTH);
        was_empty   = (mdl_tags.size() == 0);
        s.cyc       = cyc;
        s.m_valid   = (mdl_hold >= 0);
        s.req_ready = '0;
        s.rsp_done  = '0;
        s.tag_full  = full;
        s.err       = mdl_err;
        push_src    = -1;
        acc_idx     = -1;
        pop         = cdb_valid && cdb_ready;
        if (mdl_hold >= 0 && m_ready) begin
            s.req_ready[mdl_hold] = 1'b1;
            t.cyc  = cyc;
            t.src  = mdl_hold;
            t.rsv  = b_rsv[mdl_hold];
            t.op   = b_op[mdl_hold];
            t.addr = b_addr[mdl_hold];
            t.data = b_data[mdl_hold];
            txn_q.push_back(t);
            acc_idx = mdl_hold;
            if (ref_is_read(b_op[mdl_hold])) push_src = mdl_hold;
        end
        if (pop && !was_empty) s.rsp_done[mdl_tags[0]] = 1'b1;
        if (pop && was_empty && push_src >= 0) s.rsp_done[push_src] = 1'b1;
        stat_q.push_back(s);
        if (nrst) begin
            mdl_hold = -1;
            mdl_rr   = 0;
            mdl_tags.delete();
            mdl_err  = 1'b0;
        end else begin
            if (pop && !was_empty) void'(mdl_tags.pop_front());
            if (push_src >= 0 && !(pop && was_empty)) mdl_tags.push_back(push_src);
            if (pop && was_empty && push_src < 0) mdl_err = 1'b1;
            if (mdl_hold >= 0) begin
                if (m_ready) begin
                    mdl_rr   = (mdl_hold + 1) % N;
                    mdl_hold = -1;
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (mdl_rr + k) % N;
                    if (!found && b_valid[idx] && !(ref_is_read(b_op[idx]) && full)) begin
                        mdl_hold = idx;
                        found    = 1'b1;
                    end
                end
            end
        end
    endtask

    // Advance to the next cycle and retire the request accepted in the previous one.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (acc_idx >= 0) b_valid[acc_idx] = 1'b0;
        acc_idx = -1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            tick();
            eval();
        end
    endtask

    task automatic do_reset();
        tick(); nrst = 1'b1; eval();
        tick(); nrst = 1'b0; eval();
    endtask

    function automatic logic [IW-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return OP_LOAD;
            1: return OP_LOADB;
            2: return OP_LOADR;
            3: return OP_LOADT;
            4: return OP_LOADTB;
            5: return OP_INPUT;
            6: return OP_STORE;
            default: return OP_OUTPUT;
        endcase
    endfunction

    // Monitor: per-cycle status plus accepted-transaction contents.
    always @(negedge clk) begin
        stat_t s;
        txn_t  t;
        int    src;
        if (mon_en) begin
            if (stat_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL status_missing cyc=%0d actual=none required=entry", cyc);
            end else begin
                s = stat_q.pop_front();
                chk("m_valid",    64'(m_valid),    64'(s.m_valid));
                chk("req_ready",  64'(req_ready),  64'(s.req_ready));
                chk("rsp_done",   64'(rsp_done),   64'(s.rsp_done));
                chk("tag_full",   64'(tag_full),   64'(s.tag_full));
                chk("err_orphan", 64'(err_orphan), 64'(s.err));
            end
            while (txn_q.size() > 0 && txn_q[0].cyc < cyc) begin
                t = txn_q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL txn_not_accepted cyc=%0d actual=none required=src%0d@%0d", cyc, t.src, t.cyc);
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                src = -1;
                for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) src = i;
                acc_log.push_back(src);
                if (txn_q.size() == 0 || txn_q[0].cyc != cyc) begin
                    n_cmp++; n_bad++;
                    $display("FAIL txn_unexpected cyc=%0d actual=src%0d required=none", cyc, src);
                end else begin
                    t = txn_q.pop_front();
                    chk("txn_src",  64'(src),       64'(t.src));
                    chk("m_rsv_id", 64'(m_rsv_id),  64'(t.rsv));
                    chk("m_opcode", 64'(m_opcode),  64'(t.op));
                    chk("m_addr",   64'(m_address), 64'(t.addr));
                    chk("m_data",   64'(m_data),    64'(t.data));
                end
            end
        end
    end

    initial begin
        int base;
        int exp_ord[5];
        nrst = 1'b1; m_ready = 1'b0; cdb_valid = 1'b0; cdb_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            b_valid[i] = 1'b0; b_rsv[i] = '0; b_op[i] = '0; b_addr[i] = '0; b_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        eval();
        tick(); nrst = 1'b0; eval();

        // single store from requester 2
        tick(); set_req(2, OP_STORE); m_ready = 1'b1; eval();
        run(3);

        // fairness: everyone valid, requester 0 re-requests after its first grant
        do_reset();
        base = acc_log.size();
        tick(); for (int i = 0; i < N; i++) set_req(i, OP_STORE); eval();
        run(1);
        tick(); set_req(0, OP_OUTPUT); eval();
        run(8);
        #4;
        exp_ord = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (acc_log.size() > base + i) chk("grant_order", 64'(acc_log[base+i]), 64'(exp_ord[i]));
            else chk("grant_order_missing", 64'(acc_log.size()), 64'(base + 5));
        end

        // backpressure
        do_reset();
        tick(); set_req(0, OP_STORE); set_req(1, OP_STORE); m_ready = 1'b0; eval();
        run(5);
        tick(); m_ready = 1'b1; eval();
        run(4);

        // tag flow and full FIFO skip
        do_reset();
        tick(); set_req(1, OP_LOAD); eval();
        run(2);
        tick(); set_req(3, OP_LOADT); eval();
        run(2);
        tick(); set_req(0, OP_LOADB); set_req(2, OP_STORE); eval();
        run(4);
        tick(); cdb_valid = 1'b1; cdb_ready = 1'b1; eval();
        tick(); eval();
        tick(); cdb_valid = 1'b0; eval();
        run(4);
        tick(); cdb_valid = 1'b1; eval();
        tick(); cdb_valid = 1'b0; eval();

        // I_INPUT bypass
        run(2);
        tick(); set_req(2, OP_INPUT); eval();
        tick(); cdb_valid = 1'b1; eval();
        tick(); cdb_valid = 1'b0; eval();
        run(2);

        // orphan then reset while busy
        tick(); cdb_valid = 1'b1; eval();
        tick(); cdb_valid = 1'b0; eval();
        tick(); set_req(1, OP_STORE); m_ready = 1'b0; eval();
        run(3);
        tick(); nrst = 1'b1; eval();
        base = acc_log.size();
        tick(); nrst = 1'b0; set_req(0, OP_STORE); m_ready = 1'b1; eval();
        run(4);
        #4;
        if (acc_log.size() > base) chk("first_after_reset", 64'(acc_log[base]), 64'(0));
        else chk("first_after_reset_missing", 64'(acc_log.size()), 64'(base + 1));

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!b_valid[i] && $urandom_range(0, 3) == 0) set_req(i, rand_op());
            end
            m_ready   = ($urandom_range(0, 3) != 0);
            cdb_valid = ($urandom_range(0, 2) == 0);
            cdb_ready = ($urandom_range(0, 1) == 1);
            nrst      = ($urandom_range(0, 599) == 0);
            eval();
        end

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("txn_drain",  64'(txn_q.size()),  64'(0));
        chk("stat_drain", 64'(stat_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
